pipe_scoreboard: RTL and testbench
==================================

Name: pipe_scoreboard

Overview:
- Parametrised hazard and retire-tracking unit for the in-order RISC-V pipeline; successor to the fixed three-stage stall-only hazard logic.
- Keeps a shift-register scoreboard of in-flight destination registers, one slot per stage from EX to writeback.
- Drives the stall, IF/ID flush and ID/EX bubble controls.
- Produces an exact per-instruction retire strobe for the debug trace.

Parameters:
- DEPTH, 3, number of slots between ID issue and RF write (slot 1 = EX, slot DEPTH = WB); legal range 2..6.
- REG_BITS, 5, register index width.
- RF_WTHRU, 1, 1 = register file is write-through (WB write visible to an ID read in the same cycle), so slot DEPTH never causes a hazard.

Ports:
- cpu_clk  in  1  clock.
- cpu_rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1  in  REG_BITS  source register 1 index.
- id_rs1_used  in  1  instruction reads rs1.
- id_rs2  in  REG_BITS  source register 2 index.
- id_rs2_used  in  1  instruction reads rs2.
- id_rd  in  REG_BITS  destination register index.
- id_rf_we  in  1  instruction writes the RF.
- id_pc  in  32  PC of the ID instruction.
- ex_redirect  in  1  taken branch or jump resolved in slot 1 (EX).
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  load a NOP into ID/EX.
- flush_ifid  out  1  clear IF/ID to invalid.
- wb_have_inst  out  1  one instruction retires this cycle.
- wb_pc  out  32  PC of the retiring instruction.
- wb_ena  out  1  retiring instruction writes the RF.
- wb_reg  out  REG_BITS  destination of the retiring instruction.

Behaviour:
- State: slot[1..DEPTH], each {v, we, rd, pc}. On reset all fields are 0, so every output is 0.
- Hazard is combinational. hz1 is true when id_rs1_used, id_rs1 != 0, and some slot k has v, we and rd == id_rs1. k ranges over 1..DEPTH-1 when RF_WTHRU=1, or 1..DEPTH when RF_WTHRU=0. hz2 is defined the same way for rs2.
- stall = id_valid & (hz1 | hz2) & ~ex_redirect.
- flush_ifid = ex_redirect.
- bubble = stall | ex_redirect.
- Issue = id_valid & ~stall & ~ex_redirect.
- Every posedge:
  - slot[k] <= slot[k-1] for k = 2..DEPTH.
  - slot[1] <= {1, id_rf_we & (id_rd != 0), id_rd, id_pc} if Issue, else all zero.
- The slot shift never stalls; only ID holds. An instruction issued at cycle t appears at slot DEPTH during cycle t+DEPTH.
- Retire outputs are registered and come straight from slot[DEPTH]:
  - wb_have_inst = slot[DEPTH].v
  - wb_pc = slot[DEPTH].pc
  - wb_ena = slot[DEPTH].we
  - wb_reg = slot[DEPTH].rd
- Exactly one wb_have_inst pulse per issued instruction. Bubbles never pulse.
- Redirect rules:
  - The ID instruction is squashed and never issued.
  - The slot-1 instruction (the branch itself) continues and retires.
  - Redirect overrides stall in the same cycle.
- x0 destination: we forced to 0, so it never stalls a consumer; it still retires with wb_ena=0.
- Back-to-back redirects: each flushes independently, with no accumulated state.
- Reset mid-operation clears every slot immediately. No retire pulse is produced for in-flight instructions.
- Stall release: once the producer moves past the last hazard slot, stall drops in the same cycle and the consumer issues on that edge.

Optional Feature:
- Macro SB_PERF_EN.
- When defined, adds three 32-bit outputs, all reset to 0, wrapping at 2^32-1 -> 0:
  - perf_stall_cycles: +1 per cycle with stall=1.
  - perf_flushes: +1 per cycle with ex_redirect=1.
  - perf_retired: +1 per wb_have_inst.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- DEPTH=3, RF_WTHRU=1: issue addi x5 then add x6,x5,x5 back to back -> stall=1 for exactly 2 cycles, add issues on the 3rd cycle, 2 retire pulses with wb_reg 5 then 6.
- Same pair with RF_WTHRU=0 -> stall=1 for exactly 3 cycles.
- Producer writes x0, consumer reads x0 -> stall never asserts; producer retires with wb_ena=0.
- ex_redirect pulsed while ID holds a hazarding instruction with pc=0x0000_0010 -> stall=0, flush_ifid=1, bubble=1, and no retire ever reports pc 0x10.
- Assert cpu_rst with 3 instructions in flight -> all outputs 0 at once; no wb_have_inst pulse for those instructions after release.
- SB_PERF_EN defined: 10 instructions with 4 stall cycles and 1 redirect -> perf_retired=10, perf_stall_cycles=4, perf_flushes=1; perf_retired preset to 0xFFFF_FFFF wraps to 0 on the next retire.

Source files
------------

// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if: connects the in-order pipeline to its hazard/retire
// scoreboard. The pipeline (master) presents the ID instruction and the EX
// redirect. The scoreboard (slave) returns the stall/flush/bubble controls
// and the per-instruction retire strobe for the debug trace.
interface pipe_scoreboard_if #(
   parameter int REG_BITS = 5
);
   // ID stage instruction
   logic                id_valid;
   logic [REG_BITS-1:0] id_rs1;
   logic                id_rs1_used;
   logic [REG_BITS-1:0] id_rs2;
   logic                id_rs2_used;
   logic [REG_BITS-1:0] id_rd;
   logic                id_rf_we;
   logic [31:0]         id_pc;
   // EX redirect (taken branch / jump)
   logic                ex_redirect;
   // pipeline controls
   logic                stall;
   logic                bubble;
   logic                flush_ifid;
   // retire trace
   logic                wb_have_inst;
   logic [31:0]         wb_pc;
   logic                wb_ena;
   logic [REG_BITS-1:0] wb_reg;

   modport master (
      output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
             id_rd, id_rf_we, id_pc, ex_redirect,
      input  stall, bubble, flush_ifid,
             wb_have_inst, wb_pc, wb_ena, wb_reg
   );

   modport slave (
      input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
             id_rd, id_rf_we, id_pc, ex_redirect,
      output stall, bubble, flush_ifid,
             wb_have_inst, wb_pc, wb_ena, wb_reg
   );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-order pipeline hazard and retire tracker.
// A shift register holds one slot per stage from EX (slot 1) to WB
// (slot DEPTH). Each slot carries {valid, rf write, rd, pc}. A RAW hazard
// against any live writing slot stalls ID. A redirect from EX squashes the
// ID instruction and wins over a stall. The slot at WB drives the retire
// trace directly, so the retire outputs are registered.
// Optional macro SB_PERF_EN adds 32-bit wrapping counters for stall
// cycles, flushes and retired instructions.
module pipe_scoreboard #(
   parameter int DEPTH    = 3,   // 2..6
   parameter int REG_BITS = 5,
   parameter int RF_WTHRU = 1
) (
   input  logic               cpu_clk,
   input  logic               cpu_rst,
   pipe_scoreboard_if.slave   sb
`ifdef SB_PERF_EN
   ,
   output logic [31:0]        perf_stall_cycles,
   output logic [31:0]        perf_flushes,
   output logic [31:0]        perf_retired
`endif
);

   // With a write-through RF, the WB slot is already readable in ID.
   // That slot therefore drops out of the hazard window.
   localparam int HZ_LAST = (RF_WTHRU != 0) ? DEPTH - 1 : DEPTH;

   // The valid bit lives in vld_pipe. The payload lives in slot.
   typedef struct packed {
      logic                we;
      logic [REG_BITS-1:0] rd;
      logic [31:0]         pc;
   } slot_t;

   logic  [DEPTH:1] vld_pipe;
   slot_t [DEPTH:1] slot;
   slot_t           slot_nxt;

   logic [DEPTH:1]  m1, m2;
   logic            hz1, hz2;
   logic            stall;
   logic            issue;

   // Per-slot match of the ID sources against in-flight destinations.
   // Slots beyond the hazard window are tied off.
   for (genvar k = 1; k <= DEPTH; k++) begin : g_cmp
      if (k <= HZ_LAST) begin : g_on
         assign m1[k] = vld_pipe[k] & slot[k].we & (slot[k].rd == sb.id_rs1);
         assign m2[k] = vld_pipe[k] & slot[k].we & (slot[k].rd == sb.id_rs2);
      end else begin : g_off
         assign m1[k] = 1'b0;
         assign m2[k] = 1'b0;
      end
   end

   // Hazard detection and pipeline control. Reads of x0 never hazard.
   always_comb begin
      hz1   = sb.id_rs1_used & (sb.id_rs1 != '0) & (|m1);
      hz2   = sb.id_rs2_used & (sb.id_rs2 != '0) & (|m2);
      stall = sb.id_valid & (hz1 | hz2) & ~sb.ex_redirect;
      issue = sb.id_valid & ~stall & ~sb.ex_redirect;
   end

   assign sb.stall      = stall;
   assign sb.bubble     = stall | sb.ex_redirect;
   assign sb.flush_ifid = sb.ex_redirect;

   // Slot-1 payload. A write to x0 is dropped here, so x0 never blocks a
   // consumer. The instruction still retires, with wb_ena low.
   always_comb begin
      slot_nxt = '0;
      if (issue) begin
         slot_nxt.we = sb.id_rf_we & (sb.id_rd != '0);
         slot_nxt.rd = sb.id_rd;
         slot_nxt.pc = sb.id_pc;
      end
   end

   // The slot shift advances every cycle. Only ID holds on a stall, so a
   // stall or redirect inserts an empty slot (a bubble).
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         vld_pipe <= '0;
         slot     <= '0;
      end else begin
         vld_pipe <= {vld_pipe[DEPTH-1:1], issue};
         slot     <= {slot[DEPTH-1:1], slot_nxt};
      end
   end

   // The retire trace comes straight from the WB slot.
   assign sb.wb_have_inst = vld_pipe[DEPTH];
   assign sb.wb_pc        = slot[DEPTH].pc;
   assign sb.wb_ena       = slot[DEPTH].we;
   assign sb.wb_reg       = slot[DEPTH].rd;

`ifdef SB_PERF_EN
   // Free-running event counters. They wrap naturally at 2^32.
   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         perf_stall_cycles <= '0;
         perf_flushes      <= '0;
         perf_retired      <= '0;
      end else begin
         if (stall)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (sb.ex_redirect)
            perf_flushes <= perf_flushes + 32'd1;
         if (vld_pipe[DEPTH])
            perf_retired <= perf_retired + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed test of pipe_scoreboard at DEPTH=3.
// dut0 is write-through (RF_WTHRU=1) and dut1 is not. Shared stimulus is
// steered to one instance by sel. Retires are captured into a queue on
// the falling edge.
module tb_pipe_scoreboard;
   logic        cpu_clk = 1'b0;
   logic        cpu_rst = 1'b1;
   logic        sel = 1'b0;
   logic        id_valid = 1'b0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
   logic        id_rf_we = 1'b0;
   logic [31:0] id_pc = '0;
   logic        ex_redirect = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 cpu_clk = ~cpu_clk;

   pipe_scoreboard_if #(.REG_BITS(5)) if0 ();
   pipe_scoreboard_if #(.REG_BITS(5)) if1 ();

   assign if0.id_valid    = id_valid & ~sel;
   assign if1.id_valid    = id_valid & sel;
   assign if0.ex_redirect = ex_redirect & ~sel;
   assign if1.ex_redirect = ex_redirect & sel;
   assign if0.id_rs1 = id_rs1;   assign if1.id_rs1 = id_rs1;
   assign if0.id_rs2 = id_rs2;   assign if1.id_rs2 = id_rs2;
   assign if0.id_rd  = id_rd;    assign if1.id_rd  = id_rd;
   assign if0.id_pc  = id_pc;    assign if1.id_pc  = id_pc;
   assign if0.id_rf_we    = id_rf_we;  assign if1.id_rf_we    = id_rf_we;
   assign if0.id_rs1_used = 1'b1;      assign if1.id_rs1_used = 1'b1;
   assign if0.id_rs2_used = 1'b1;      assign if1.id_rs2_used = 1'b1;

`ifdef SB_PERF_EN
   logic [31:0] p0_stall, p0_flush, p0_ret, p1_stall, p1_flush, p1_ret;
`endif

   pipe_scoreboard #(.DEPTH(3), .REG_BITS(5), .RF_WTHRU(1)) dut0 (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .sb(if0.slave)
`ifdef SB_PERF_EN
      , .perf_stall_cycles(p0_stall), .perf_flushes(p0_flush), .perf_retired(p0_ret)
`endif
   );

   pipe_scoreboard #(.DEPTH(3), .REG_BITS(5), .RF_WTHRU(0)) dut1 (
      .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .sb(if1.slave)
`ifdef SB_PERF_EN
      , .perf_stall_cycles(p1_stall), .perf_flushes(p1_flush), .perf_retired(p1_ret)
`endif
   );

   // observed outputs of the selected instance
   logic        stall_o, bubble_o, flush_o, wbv_o, wbe_o;
   logic [31:0] wbpc_o;
   logic [4:0]  wbr_o;
   assign stall_o  = sel ? if1.stall        : if0.stall;
   assign bubble_o = sel ? if1.bubble       : if0.bubble;
   assign flush_o  = sel ? if1.flush_ifid   : if0.flush_ifid;
   assign wbv_o    = sel ? if1.wb_have_inst : if0.wb_have_inst;
   assign wbe_o    = sel ? if1.wb_ena       : if0.wb_ena;
   assign wbpc_o   = sel ? if1.wb_pc        : if0.wb_pc;
   assign wbr_o    = sel ? if1.wb_reg       : if0.wb_reg;

   typedef struct packed {
      logic        ena;
      logic [4:0]  rg;
      logic [31:0] pc;
   } ret_t;
   ret_t rq[$];

   // capture every retire pulse
   always @(negedge cpu_clk)
      if (wbv_o) rq.push_back('{ena: wbe_o, rg: wbr_o, pc: wbpc_o});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Entered at posedge+1. Presents one instruction and holds it while
   // stalled, then returns at posedge+1 after the issuing edge with ID idle.
   task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] pc,
                        output int stalls);
      stalls   = 0;
      id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
      id_rf_we = 1'b1; id_pc = pc;
      #1;
      while (stall_o && stalls < 20) begin
         chk("stall_bubble", bubble_o, 1'b1);
         chk("stall_noflush", flush_o, 1'b0);
         stalls++;
         @(posedge cpu_clk); #2;
      end
      chk("issue_nobubble", bubble_o, 1'b0);
      @(posedge cpu_clk); #1;
      id_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      repeat (n) @(posedge cpu_clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      int bad;
      // reset state
      #3;
      chk("rst_stall", stall_o, 0);
      chk("rst_bubble", bubble_o, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_wbv", wbv_o, 0);
      chk("rst_wbpc", wbpc_o, 0);
      @(posedge cpu_clk); @(posedge cpu_clk); #1;
      cpu_rst = 1'b0;
      @(posedge cpu_clk); #1;

      // 1: write-through, addi x5 then add x6,x5,x5 -> 2 stall cycles
      sel = 1'b0; rq.delete();
      issue(5'd0, 5'd0, 5'd5, 32'h100, s); chk("t1_p_stall", s, 0);
      issue(5'd5, 5'd5, 5'd6, 32'h104, s); chk("t1_c_stall", s, 2);
      drain(6);
      chk("t1_nret", rq.size(), 2);
      if (rq.size() == 2) begin
         chk("t1_reg0", rq[0].rg, 5);  chk("t1_pc0", rq[0].pc, 32'h100);
         chk("t1_reg1", rq[1].rg, 6);  chk("t1_pc1", rq[1].pc, 32'h104);
         chk("t1_ena1", rq[1].ena, 1);
      end

      // 2: non write-through, same pair -> 3 stall cycles
      sel = 1'b1; rq.delete();
      issue(5'd0, 5'd0, 5'd5, 32'h100, s); chk("t2_p_stall", s, 0);
      issue(5'd5, 5'd5, 5'd6, 32'h104, s); chk("t2_c_stall", s, 3);
      drain(6);
      chk("t2_nret", rq.size(), 2);
      if (rq.size() == 2) begin
         chk("t2_reg0", rq[0].rg, 5);
         chk("t2_reg1", rq[1].rg, 6);
      end

      // 3: x0 producer and consumer never stall, producer retires wb_ena=0
      sel = 1'b0; rq.delete();
      issue(5'd0, 5'd0, 5'd0, 32'h200, s); chk("t3_p_stall", s, 0);
      issue(5'd0, 5'd0, 5'd7, 32'h204, s); chk("t3_c_stall", s, 0);
      drain(6);
      chk("t3_nret", rq.size(), 2);
      if (rq.size() == 2) begin
         chk("t3_ena0", rq[0].ena, 0);  chk("t3_pc0", rq[0].pc, 32'h200);
         chk("t3_ena1", rq[1].ena, 1);  chk("t3_reg1", rq[1].rg, 7);
      end

      // 4: back-to-back redirects squash hazarding ID instructions
      rq.delete();
      issue(5'd0, 5'd0, 5'd9, 32'h300, s);
      id_valid = 1'b1; id_rs1 = 5'd9; id_rs2 = 5'd9; id_rd = 5'd1; id_pc = 32'h10;
      ex_redirect = 1'b1;
      #1;
      chk("t4_stall", stall_o, 0);
      chk("t4_flush", flush_o, 1);
      chk("t4_bubble", bubble_o, 1);
      @(posedge cpu_clk); #1;
      id_pc = 32'h14;
      #1;
      chk("t4b_stall", stall_o, 0);
      chk("t4b_flush", flush_o, 1);
      chk("t4b_bubble", bubble_o, 1);
      @(posedge cpu_clk); #1;
      ex_redirect = 1'b0; id_valid = 1'b0;
      #1;
      chk("t4_flush_off", flush_o, 0);
      drain(6);
      chk("t4_nret", rq.size(), 1);
      bad = 0;
      foreach (rq[i]) if (rq[i].pc == 32'h10 || rq[i].pc == 32'h14) bad++;
      chk("t4_squashed_ret", bad, 0);

      // 5: reset with 3 instructions in flight
      rq.delete();
      issue(5'd0, 5'd0, 5'd11, 32'h400, s);
      issue(5'd0, 5'd0, 5'd12, 32'h404, s);
      issue(5'd0, 5'd0, 5'd13, 32'h408, s);
      cpu_rst = 1'b1;
      #1;
      chk("t5_wbv", wbv_o, 0);
      chk("t5_wbpc", wbpc_o, 0);
      chk("t5_wbreg", wbr_o, 0);
      @(posedge cpu_clk); @(posedge cpu_clk); #1;
      cpu_rst = 1'b0;
      drain(6);
      chk("t5_nret", rq.size(), 0);

`ifdef SB_PERF_EN
      // 6: perf counters, 10 instructions, 4 stall cycles, 1 redirect
      rq.delete();
      issue(5'd0, 5'd0, 5'd14, 32'h500, s);
      issue(5'd14, 5'd0, 5'd15, 32'h504, s); chk("t6_s1", s, 2);
      issue(5'd0, 5'd0, 5'd16, 32'h508, s);
      issue(5'd0, 5'd16, 5'd17, 32'h50c, s); chk("t6_s2", s, 2);
      for (int i = 0; i < 6; i++) issue(5'd0, 5'd0, 5'd20, 32'h510 + 4 * i, s);
      ex_redirect = 1'b1;
      @(posedge cpu_clk); #1;
      ex_redirect = 1'b0;
      drain(6);
      chk("t6_retired", p0_ret, 10);
      chk("t6_stalls", p0_stall, 4);
      chk("t6_flushes", p0_flush, 1);
      force dut0.perf_retired = 32'hFFFF_FFFF;
      #1;
      release dut0.perf_retired;
      issue(5'd0, 5'd0, 5'd21, 32'h600, s);
      drain(6);
      chk("t6_wrap", p0_ret, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
